mdu_hilo: RTL and testbench
===========================

# mdu_hilo

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS datapath. It sits beside the EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from ID/EX and computes products and quotients over several cycles. While busy, the hazard logic stalls any MFHI/MFLO or new MDU op.

## Interface
- WIDTH, 32, operand width; even, >= 4; HI and LO are each WIDTH bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  operation code (mdu_pkg): 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110/111 reserved
- a  in  WIDTH  rs operand / dividend / MTHI-MTLO source
- b  in  WIDTH  rt operand / divisor
- abort  in  1  pipeline flush; cancels the in-flight op
- busy  out  1  unit occupied; stall request to hazard unit
- done  out  1  one-cycle pulse; HI/LO updated and valid
- dz  out  1  divide-by-zero flag, valid while done=1
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIN.
- IDLE + start + valid op + !abort:
  - MULT*/DIV*: latch operands, clear counter, go to RUN.
  - MTHI/MTLO: write a into hi/lo at that same edge, stay IDLE, pulse done next cycle.
- Reserved op: ignored; no state change, no done.
- Operand preparation:
  - Signed ops take magnitudes.
  - Result sign = sign(a) xor sign(b).
  - Remainder sign = sign(a).
- RUN: exactly WIDTH iterations, one bit per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient bits into LO, partial remainder into HI.
  - Counter is log2(WIDTH)+1 bits; leaves RUN after the iteration with count = WIDTH-1.
- FIN: apply sign correction (two's-complement negate of product, quotient, and/or remainder as required).
  - At the edge leaving FIN: write hi/lo, go to IDLE, assert done for the next cycle.
- Results:
  - MULT*: {hi,lo} = full 2*WIDTH product.
  - DIV*: lo = quotient, hi = remainder.
- Divide by zero, signed or unsigned: lo = all ones, hi = a (unmodified dividend), dz = 1 with done. The unit still runs the full latency.
- Signed overflow (a = most-negative, b = -1): lo = most-negative, hi = 0. This falls out of the magnitude arithmetic; no special case is needed.
- abort in RUN or FIN: go to IDLE at the next edge. hi/lo are unchanged and no done is produced.
- abort in IDLE has priority over start: the request is dropped.
- start while busy: ignored and not queued.

## Timing
- Reset values: state IDLE, hi = 0, lo = 0, busy = 0, done = 0, dz = 0.
- Reset during RUN/FIN discards the operation and clears hi/lo.
- Call the start-accepting edge E0.
  - busy = 1 from E0 through the cycle ending at edge E0+WIDTH+1 (WIDTH cycles RUN + 1 cycle FIN).
  - hi/lo written at E0+WIDTH+1; done = 1 and busy = 0 in the following cycle.
  - Latency is WIDTH+1 cycles to result write, identical for all mul/div ops, signed or not.
- Back-to-back: a new start is accepted in the same cycle that done is high.
- MTHI/MTLO: zero busy cycles; register visible the cycle after E0.
- busy is a registered output (decoded from state); done and dz are registered.

## Configuration
- MDU_SIGNED_EN defined: MULT/DIV perform signed arithmetic as above.
- MDU_SIGNED_EN undefined:
  - MULT/DIV execute as MULTU/DIVU; sign-correction logic is removed.
  - The FIN cycle is retained, so latency is unchanged.

## Structure
- mdu_pkg holds:
  - op code localparams: MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV, MDU_MTHI, MDU_MTLO
  - state encoding: MDU_IDLE, MDU_RUN, MDU_FIN
- One sub-module: twos_mag (parametrised WIDTH). Conditional two's-complement negate, used for both operand magnitudes and result sign correction.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after start edge; busy high 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); same build without MDU_SIGNED_EN -> hi=0x00000006, lo=0xFFFFFFEB.
- DIVU a=100, b=7 -> lo=14, hi=2; DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234, dz=1 with done; next op -> dz=0.
- Preload hi=lo=0x55; DIVU started, abort asserted at RUN iteration 10 -> busy=0 next cycle, no done, hi/lo still 0x55. start pulsed mid-RUN -> ignored; result matches the first op only.
- MTHI a=0xDEADBEEF -> hi=0xDEADBEEF next cycle, lo unchanged, busy never set. rst low mid-MULT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Op codes and FSM state encoding for the mdu_hilo unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam logic [2:0] MDU_MULTU = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_DIVU  = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIN  = 2'd2
  } mdu_state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_hilo_twos_mag.sv
// ============================================================================
// Module      : twos_mag
// Description : Conditional two's-complement negate (magnitude / sign fix).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module twos_mag #(
  parameter int WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

`default_nettype wire

// File: rtl/mdu_hilo.sv
// ============================================================================
// Module      : mdu_hilo
// Description : Iterative multiply/divide unit with HI/LO registers.
//               Define MDU_SIGNED_EN to enable signed MULT/DIV.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdu_state_e           state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opd_q, a_q;
  logic [WIDTH-1:0]     hi_q, lo_q, hi_d, lo_d;
  logic                 is_div_q, dz_pend_q;
  logic                 busy_q, done_q, dz_q;

  logic                 op_arith, op_div, accept;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic [WIDTH:0]       mul_sum, div_trial;

  assign op_div   = (op == MDU_DIVU) || (op == MDU_DIV);
  assign op_arith = op_div || (op == MDU_MULTU) || (op == MDU_MULT);
  assign accept   = (state_q == MDU_IDLE) && start && !abort && op_arith;

`ifdef MDU_SIGNED_EN
  logic neg_res_q, neg_rem_q;

  twos_mag #(.WIDTH(WIDTH)) u_mag_a (
    .neg_i (op[0] & a[WIDTH-1]), .val_i (a), .res_o (mag_a)
  );
  twos_mag #(.WIDTH(WIDTH)) u_mag_b (
    .neg_i (op[0] & b[WIDTH-1]), .val_i (b), .res_o (mag_b)
  );
  twos_mag #(.WIDTH(2*WIDTH)) u_fix_prod (
    .neg_i (neg_res_q), .val_i (acc_q), .res_o (prod_fix)
  );
  twos_mag #(.WIDTH(WIDTH)) u_fix_quo (
    .neg_i (neg_res_q), .val_i (acc_q[WIDTH-1:0]), .res_o (quo_fix)
  );
  twos_mag #(.WIDTH(WIDTH)) u_fix_rem (
    .neg_i (neg_rem_q), .val_i (acc_q[2*WIDTH-1:WIDTH]), .res_o (rem_fix)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      neg_res_q <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem_q <= op[0] & a[WIDTH-1];
    end
  end
`else
  assign mag_a    = a;
  assign mag_b    = b;
  assign prod_fix = acc_q;
  assign quo_fix  = acc_q[WIDTH-1:0];
  assign rem_fix  = acc_q[2*WIDTH-1:WIDTH];
`endif

  // Multiply keeps the multiplier in the low half and shifts the product in
  // from the top; divide keeps the partial remainder in the high half and
  // shifts quotient bits in from the bottom.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     (acc_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};

  always_comb begin
    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (!div_trial[WIDTH]) begin
        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    {hi_d, lo_d} = prod_fix;
    if (dz_pend_q) begin
      hi_d = a_q;
      lo_d = {WIDTH{1'b1}};
    end else if (is_div_q) begin
      hi_d = rem_fix;
      lo_d = quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      a_q       <= '0;
      is_div_q  <= 1'b0;
      dz_pend_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        MDU_IDLE: begin
          if (start && !abort) begin
            if (op == MDU_MTHI) begin
              hi_q   <= a;
              done_q <= 1'b1;
            end else if (op == MDU_MTLO) begin
              lo_q   <= a;
              done_q <= 1'b1;
            end else if (op_arith) begin
              state_q   <= MDU_RUN;
              busy_q    <= 1'b1;
              cnt_q     <= '0;
              is_div_q  <= op_div;
              opd_q     <= op_div ? mag_b : mag_a;
              acc_q     <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
              a_q       <= a;
              dz_pend_q <= op_div && (b == '0);
            end
          end
        end
        MDU_RUN: begin
          if (abort) begin
            state_q <= MDU_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_q <= MDU_FIN;
            end
          end
        end
        MDU_FIN: begin
          state_q <= MDU_IDLE;
          busy_q  <= 1'b0;
          if (!abort) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= 1'b1;
            dz_q   <= dz_pend_q;
          end
        end
        default: begin
          state_q <= MDU_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// ============================================================================
// Module      : tb_mdu_hilo
// Description : Directed self-checking bench for mdu_hilo (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_hilo;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, abort;
  logic [2:0]   op;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, dz;

  int n_cmp = 0;
  int n_bad = 0;
  int lat, bcnt;
  logic seen;

  always #5 clk = ~clk;

  mdu_hilo #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle (or timeout).
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int l, output int bc);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    l  = 1;
    bc = 0;
    while (!done && l < 100) begin
      if (busy) bc++;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic arith(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic edz);
    int l, bc;
    run_op(o, x, y, l, bc);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_lat"}, l, 34);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_dz"}, dz, edz);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", dz, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    check("multu_done", done, 1'b1);
    check("multu_lat", lat, 34);
    check("multu_busy_cycles", bcnt, 33);
    check("multu_busy_at_done", busy, 1'b0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // Back-to-back: each op below starts in the previous op's done cycle.
`ifdef MDU_SIGNED_EN
    arith("mult_neg", 3'b001, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    arith("div_neg", 3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    arith("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
`else
    arith("mult_neg", 3'b001, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0);
    arith("div_neg", 3'b011, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    arith("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0);
`endif
    arith("divu", 3'b010, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    arith("divu_dz", 3'b010, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
    arith("after_dz", 3'b000, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

    @(negedge clk);
    run_op(3'b100, 32'h55, 32'h0, lat, bcnt);
    check("mthi55_lat", lat, 1);
    run_op(3'b101, 32'h55, 32'h0, lat, bcnt);
    check("mtlo55_lat", lat, 1);
    check("preload_hi", hi, 32'h55);
    check("preload_lo", lo, 32'h55);

    // Abort at RUN iteration 10.
    @(negedge clk);
    start = 1'b1; op = 3'b010; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", seen, 1'b0);
    check("abort_hi", hi, 32'h55);
    check("abort_lo", lo, 32'h55);

    // abort in IDLE drops a simultaneous request.
    start = 1'b1; abort = 1'b1; op = 3'b100; a = 32'h77;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_done", done, 1'b0);
    check("idle_abort_hi", hi, 32'h55);

    // start pulsed mid-RUN is ignored.
    start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      start = (lat == 5);
      if (lat == 5) begin
        op = 3'b000; a = 32'd3; b = 32'd5;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("midrun_done", done, 1'b1);
    check("midrun_lat", lat, 34);
    check("midrun_hi", hi, 32'd2);
    check("midrun_lo", lo, 32'd14);
    @(negedge clk);
    check("midrun_not_queued", busy, 1'b0);

    run_op(3'b100, 32'hDEAD_BEEF, 32'h0, lat, bcnt);
    check("mthi_lat", lat, 1);
    check("mthi_busy_cycles", bcnt, 0);
    check("mthi_busy", busy, 1'b0);
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_lo", lo, 32'd14);

    // Reset mid-MULT.
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_dz", dz, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
